// File: rtl/text_console.sv
// Character-cell terminal front end: interprets a byte stream into a 40x30
// cell buffer with cursor, wrap and hardware scroll, plus a renderer read port.
module text_console #(
  parameter int unsigned COLS   = 40,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned CELLS  = 1200,
  parameter int unsigned ADDR_W = 11,
  parameter logic [7:0]  BLANK  = 8'h20
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [5:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  typedef enum logic [1:0] {CLEAR, IDLE, SCROLL, FILL} state_t;

  localparam logic [ADDR_W-1:0] NCELLS     = ADDR_W'(CELLS);
  localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW_A = ADDR_W'(CELLS - COLS);
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(COLS);
  localparam logic [5:0]        LAST_COL   = 6'(COLS - 1);
  localparam logic [4:0]        LAST_ROW   = 5'(ROWS - 1);

  state_t            state;
  logic [7:0]        mem [CELLS];
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] cur_addr;
  logic [5:0]        col;
  logic [4:0]        row;
  logic              clr_pend;
  logic [7:0]        scroll_data;

  logic              accept;
  logic              printable;
  logic              to_scroll;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;

  assign in_ready   = (state == IDLE) && !clear;
  assign busy       = (state != IDLE);
  assign accept     = in_valid && in_ready;
  assign printable  = !in_data[7] && (in_data >= 8'h20);
  assign to_scroll  = accept && (row == LAST_ROW) &&
                      ((printable && col == LAST_COL) || in_data == 8'h0A);
  assign cursor_col = col;
  assign cursor_row = row;

  // Scroll writes lag their reads by one cycle, so idx==0 is a read-only cycle.
  always_comb begin
    we    = 1'b0;
    waddr = cur_addr;
    wdata = BLANK;
    case (state)
      CLEAR, FILL: begin
        we    = 1'b1;
        waddr = idx;
      end
      SCROLL: begin
        if (idx != '0) begin
          we    = 1'b1;
          waddr = idx - 1'b1;
          wdata = scroll_data;
        end
      end
      IDLE: begin
        if (accept && printable) begin
          we    = 1'b1;
          wdata = in_data;
        end else if (accept && in_data == 8'h08 && col != '0) begin
          we    = 1'b1;
          waddr = cur_addr - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (we) mem[waddr] <= wdata;
    if (state == SCROLL && idx != LAST_ROW_A) scroll_data <= mem[idx + ROW_STEP];
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= (rd_addr < NCELLS) ? mem[rd_addr] : BLANK;
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state    <= CLEAR;
      idx      <= '0;
      col      <= '0;
      row      <= '0;
      cur_addr <= '0;
      clr_pend <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (idx == LAST_CELL) begin
            state    <= IDLE;
            idx      <= '0;
            col      <= '0;
            row      <= '0;
            cur_addr <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        IDLE: begin
          if (clear) begin
            state <= CLEAR;
            idx   <= '0;
          end else if (to_scroll) begin
            state    <= SCROLL;
            idx      <= '0;
            col      <= '0;
            cur_addr <= LAST_ROW_A;
          end else if (in_valid) begin
            if (printable) begin
              cur_addr <= cur_addr + 1'b1;
              if (col == LAST_COL) begin
                col <= '0;
                row <= row + 5'd1;
              end else begin
                col <= col + 6'd1;
              end
            end else if (in_data == 8'h0D) begin
              col      <= '0;
              cur_addr <= cur_addr - ADDR_W'(col);
            end else if (in_data == 8'h0A) begin
              col      <= '0;
              row      <= row + 5'd1;
              cur_addr <= cur_addr - ADDR_W'(col) + ROW_STEP;
            end else if (in_data == 8'h08) begin
              if (col != '0) begin
                col      <= col - 6'd1;
                cur_addr <= cur_addr - 1'b1;
              end
            end else if (in_data == 8'h0C) begin
              state <= CLEAR;
              idx   <= '0;
            end
          end
        end
        SCROLL: begin
          if (clear) clr_pend <= 1'b1;
          // FILL continues from the first cell of the bottom row.
          if (idx == LAST_ROW_A) state <= FILL;
          else                   idx   <= idx + 1'b1;
        end
        FILL: begin
          if (idx == LAST_CELL) begin
            clr_pend <= 1'b0;
            if (clr_pend || clear) begin
              state <= CLEAR;
              idx   <= '0;
            end else begin
              state    <= IDLE;
              idx      <= '0;
              row      <= LAST_ROW;
              col      <= '0;
              cur_addr <= LAST_ROW_A;
            end
          end else begin
            if (clear) clr_pend <= 1'b1;
            idx <= idx + 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: terminal-level screen model compared every cycle,
// plus directed literal checks on cursor, cell contents and busy durations.
module tb_text_console;
  localparam int COLS  = 40;
  localparam int ROWS  = 30;
  localparam int CELLS = 1200;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        clear = 1'b0;
  logic [10:0] rd_addr = '0;
  logic        in_ready;
  logic [7:0]  rd_data;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  text_console #(.COLS(40), .ROWS(30), .CELLS(1200), .ADDR_W(11), .BLANK(8'h20)) dut (
    .pclk(pclk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear), .rd_addr(rd_addr), .rd_data(rd_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Screen model: final contents after each operation plus remaining busy cycles.
  logic [7:0] mm [CELLS];
  int   mrow = 0, mcol = 0, busy_cnt = 1200;
  bit   clearing = 1'b1, pend = 1'b0, rd_chk = 1'b0;
  logic [7:0] exp_rd = '0;

  function automatic void m_clear();
    for (int i = 0; i < CELLS; i++) mm[i] = 8'h20;
    mrow = 0; mcol = 0; busy_cnt = 1200; clearing = 1'b1; pend = 1'b0;
  endfunction

  function automatic void m_scroll();
    for (int i = 0; i < CELLS - COLS; i++) mm[i] = mm[i + COLS];
    for (int i = CELLS - COLS; i < CELLS; i++) mm[i] = 8'h20;
    mrow = ROWS - 1; mcol = 0; busy_cnt = 1201; clearing = 1'b0;
  endfunction

  function automatic void m_byte(logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7F) begin
      mm[mrow * COLS + mcol] = b;
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        if (mrow == ROWS - 1) m_scroll(); else mrow++;
      end
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0A) begin
      mcol = 0;
      if (mrow == ROWS - 1) m_scroll(); else mrow++;
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        mm[mrow * COLS + mcol] = 8'h20;
      end
    end else if (b == 8'h0C) begin
      m_clear();
    end
  endfunction

  always @(posedge pclk) begin
    rd_chk = !reset && busy_cnt == 0;
    exp_rd = (rd_addr < CELLS) ? mm[rd_addr] : 8'h20;
    if (reset) m_clear();
    else if (busy_cnt > 0) begin
      if (clear && !clearing) pend = 1'b1;
      busy_cnt--;
      if (busy_cnt == 0 && pend) m_clear();
    end else if (clear) m_clear();
    else if (in_valid) m_byte(in_data);
  end

  always @(negedge pclk) begin
    chk("busy", busy, busy_cnt > 0);
    chk("in_ready", in_ready, busy_cnt == 0 && !clear);
    if (busy_cnt == 0) begin
      chk("cursor_col", cursor_col, mcol);
      chk("cursor_row", cursor_row, mrow);
    end
    if (rd_chk) chk("rd_data", rd_data, exp_rd);
  end

  task automatic tick();
    @(posedge pclk);
    #2;
  endtask

  task automatic send(logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(posedge pclk);
      n++;
      @(negedge pclk);
    end while (busy && n < 5000);
    if (busy) chk("idle_timeout", 1, 0);
    tick();
  endtask

  task automatic read_chk(string name, logic [10:0] a, logic [7:0] exp);
    rd_addr = a;
    tick();
    chk(name, rd_data, exp);
  endtask

  task automatic sweep();
    for (int a = 0; a < CELLS; a++) begin
      rd_addr = 11'(a);
      tick();
    end
    rd_addr = 11'd1200; tick();
    rd_addr = 11'd2047; tick();
    rd_addr = '0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) tick();
    reset = 1'b0;
    wait_idle(n);
    chk("reset_clear_cycles", n, 1200);
    chk("reset_col", cursor_col, 0);
    chk("reset_row", cursor_row, 0);
    read_chk("reset_cell0", 11'd0, 8'h20);
    sweep();

    send(8'h41); send(8'h42); send(8'h0D); send(8'h43);
    read_chk("abc_cell0", 11'd0, 8'h43);
    read_chk("abc_cell1", 11'd1, 8'h42);
    chk("abc_col", cursor_col, 1);
    chk("abc_row", cursor_row, 0);

    send(8'h0C);
    wait_idle(n);
    chk("ff_clear_cycles", n, 1200);
    for (int i = 0; i < 41; i++) send(8'h41);
    read_chk("wrap_cell39", 11'd39, 8'h41);
    read_chk("wrap_cell40", 11'd40, 8'h41);
    read_chk("wrap_cell41", 11'd41, 8'h20);
    chk("wrap_col", cursor_col, 1);
    chk("wrap_row", cursor_row, 1);

    send(8'h0C);
    wait_idle(n);
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) send(8'(8'h30 + r % 10));
    for (int c = 0; c < COLS - 1; c++) send(8'h39);
    send(8'h0A);
    wait_idle(n);
    chk("scroll_cycles", n, 1201);
    read_chk("scroll_cell0", 11'd0, 8'h31);
    read_chk("scroll_cell1120", 11'd1120, 8'h39);
    read_chk("scroll_cell1159", 11'd1159, 8'h20);
    read_chk("scroll_cell1160", 11'd1160, 8'h20);
    chk("scroll_row", cursor_row, 29);
    chk("scroll_col", cursor_col, 0);
    sweep();

    in_data = 8'h51; in_valid = 1'b1; clear = 1'b1;
    tick();
    in_valid = 1'b0; clear = 1'b0;
    wait_idle(n);
    chk("pin_clear_cycles", n, 1200);
    read_chk("clear_drops_byte", 11'd0, 8'h20);
    send(8'h08);
    chk("bs_noop_col", cursor_col, 0);
    send(8'h58); send(8'h08);
    read_chk("bs_cell0", 11'd0, 8'h20);
    chk("bs_col", cursor_col, 0);
    send(8'h01); send(8'h80);
    chk("ignored_col", cursor_col, 0);

    for (int i = 0; i < ROWS; i++) send(8'h0A);
    repeat (100) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_idle(n);
    chk("scroll_clear_cycles", n, 2300);
    chk("scroll_clear_row", cursor_row, 0);
    sweep();

    send(8'h5A);
    for (int i = 0; i < ROWS; i++) send(8'h0A);
    repeat (50) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_idle(n);
    chk("reset_mid_scroll_cycles", n, 1200);
    read_chk("reset_mid_scroll_cell0", 11'd0, 8'h20);
    sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
